// File: rtl/ahb_ic_pkg.sv
// ============================================================================
// ahb_ic_pkg : shared encodings for the AHB-Lite decoder / response mux
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_ic_pkg;

   localparam int NSLV = 4;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [2:0] {
      SEL_S0  = 3'd0,
      SEL_S1  = 3'd1,
      SEL_S2  = 3'd2,
      SEL_S3  = 3'd3,
      SEL_DEF = 3'd4
   } sel_t;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   // True for transfers that demand a response (NONSEQ/SEQ).
   function automatic logic is_active(input logic [1:0] trans);
      logic act;
      case (trans)
         HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
         default:                   act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_default_slave.sv
// ============================================================================
// ahb_default_slave : two-cycle ERROR responder for unmapped addresses,
// with optional first-error log (AHB_ERR_LOG_EN). Rev 1.0
// ============================================================================
`default_nettype none

module ahb_default_slave
   import ahb_ic_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hready,
   input  logic        trans_active,
   input  logic        dec_miss,
   input  logic [31:0] haddr,
   input  logic        err_clr,
   output logic        ds_hready,
   output logic        ds_hresp,
   output logic        err_valid,
   output logic [31:0] err_addr
);

   ds_state_t state;
   ds_state_t state_nxt;
   logic      take_err;

   // An unmapped transfer is only accepted when the bus is ready.
   assign take_err = hready && dec_miss && trans_active;

   always_ff @(posedge clk) begin
      if (rst) state <= DS_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ds_hready = 1'b1;
      ds_hresp  = 1'b0;
      case (state)
         DS_IDLE: begin
            if (take_err) state_nxt = DS_ERR1;
         end
         DS_ERR1: begin
            ds_hready = 1'b0;
            ds_hresp  = 1'b1;
            state_nxt = DS_ERR2;
         end
         DS_ERR2: begin
            ds_hresp  = 1'b1;
            state_nxt = take_err ? DS_ERR1 : DS_IDLE;
         end
         default: state_nxt = DS_IDLE;
      endcase
   end

`ifdef AHB_ERR_LOG_EN
   logic        log_valid;
   logic [31:0] log_addr;
   logic        capture;

   // A clear in the same cycle as a fresh error lets the new address in.
   assign capture = (state == DS_IDLE) && take_err && (!log_valid || err_clr);

   always_ff @(posedge clk) begin
      if (rst) begin
         log_valid <= 1'b0;
         log_addr  <= '0;
      end else if (capture) begin
         log_valid <= 1'b1;
         log_addr  <= haddr;
      end else if (err_clr) begin
         log_valid <= 1'b0;
         log_addr  <= '0;
      end
   end

   assign err_valid = log_valid;
   assign err_addr  = log_addr;
`else
   logic unused_log;
   assign unused_log = ^{err_clr, haddr};
   assign err_valid  = 1'b0;
   assign err_addr   = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/ahb_lite_interconnect.sv
// ============================================================================
// ahb_lite_interconnect : single-master AHB-Lite decoder + response mux,
// unmapped space answered by ahb_default_slave (log via AHB_ERR_LOG_EN). Rev 1.0
// ============================================================================
`default_nettype none

module ahb_lite_interconnect
   import ahb_ic_pkg::*;
#(
   parameter logic [7:0] S0_REGION = 8'h00,
   parameter logic [7:0] S1_REGION = 8'h50,
   parameter logic [7:0] S2_REGION = 8'h51,
   parameter logic [7:0] S3_REGION = 8'h52
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   output logic [NSLV-1:0]      HSEL_S,
   input  logic [32*NSLV-1:0]   HRDATA_S,
   input  logic [NSLV-1:0]      HREADYOUT_S,
   input  logic [NSLV-1:0]      HRESP_S,
   output logic [31:0]          HRDATA,
   output logic                 HREADY,
   output logic                 HRESP,
   input  logic                 ERR_CLR,
   output logic                 ERR_VALID,
   output logic [31:0]          ERR_ADDR
);

   localparam logic [8*NSLV-1:0] REGIONS = {S3_REGION, S2_REGION, S1_REGION, S0_REGION};

   logic [NSLV-1:0] hit;
   logic            miss;
   sel_t            dec_sel;
   sel_t            sel_q;
   logic            ds_hready;
   logic            ds_hresp;

   for (genvar i = 0; i < NSLV; i++) begin : g_dec
      assign hit[i] = (HADDR[31:24] == REGIONS[8*i +: 8]);
   end

   assign HSEL_S = hit;
   assign miss   = ~|hit;

   always_comb begin
      dec_sel = SEL_DEF;
      if      (hit[0]) dec_sel = SEL_S0;
      else if (hit[1]) dec_sel = SEL_S1;
      else if (hit[2]) dec_sel = SEL_S2;
      else if (hit[3]) dec_sel = SEL_S3;
   end

   // Data-phase owner; frozen while the current transfer is stretched.
   always_ff @(posedge HCLK) begin
      if (HRESET)      sel_q <= SEL_DEF;
      else if (HREADY) sel_q <= dec_sel;
   end

   always_comb begin
      HRDATA = '0;
      HREADY = ds_hready;
      HRESP  = ds_hresp;
      case (sel_q)
         SEL_S0: begin
            HRDATA = HRDATA_S[31:0];
            HREADY = HREADYOUT_S[0];
            HRESP  = HRESP_S[0];
         end
         SEL_S1: begin
            HRDATA = HRDATA_S[63:32];
            HREADY = HREADYOUT_S[1];
            HRESP  = HRESP_S[1];
         end
         SEL_S2: begin
            HRDATA = HRDATA_S[95:64];
            HREADY = HREADYOUT_S[2];
            HRESP  = HRESP_S[2];
         end
         SEL_S3: begin
            HRDATA = HRDATA_S[127:96];
            HREADY = HREADYOUT_S[3];
            HRESP  = HRESP_S[3];
         end
         default: ;
      endcase
   end

   ahb_default_slave u_default_slave (
      .clk          (HCLK),
      .rst          (HRESET),
      .hready       (HREADY),
      .trans_active (is_active(HTRANS)),
      .dec_miss     (miss),
      .haddr        (HADDR),
      .err_clr      (ERR_CLR),
      .ds_hready    (ds_hready),
      .ds_hresp     (ds_hresp),
      .err_valid    (ERR_VALID),
      .err_addr     (ERR_ADDR)
   );

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_interconnect.sv
// ============================================================================
// tb_ahb_lite_interconnect : table-driven scoreboard bench for the interconnect
// ============================================================================
`default_nettype none

module tb_ahb_lite_interconnect;

`ifdef AHB_ERR_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] BZ = 2'b01;
   localparam logic [1:0] NS = 2'b10;

   logic          HCLK;
   logic          HRESET;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic [3:0]    HSEL_S;
   logic [127:0]  HRDATA_S;
   logic [3:0]    HREADYOUT_S;
   logic [3:0]    HRESP_S;
   logic [31:0]   HRDATA;
   logic          HREADY;
   logic          HRESP;
   logic          ERR_CLR;
   logic          ERR_VALID;
   logic [31:0]   ERR_ADDR;

   ahb_lite_interconnect dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL_S      (HSEL_S),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .ERR_CLR     (ERR_CLR),
      .ERR_VALID   (ERR_VALID),
      .ERR_ADDR    (ERR_ADDR)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        rst;
      logic        clr;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [3:0]  rdy;
      logic [3:0]  resp;
      logic        chk;
      logic [3:0]  hsel;
      logic        ready;
      logic        hresp;
      logic [31:0] rdata;
      logic        ev;     // expected ERR_VALID when logging is built in
      logic [31:0] ea;     // expected ERR_ADDR when logging is built in
   } vec_t;

   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic rst, input logic clr, input logic [31:0] addr,
                               input logic [1:0] trans, input logic [3:0] rdy, input logic [3:0] resp,
                               input logic chk, input logic [3:0] hsel, input logic ready,
                               input logic hresp, input logic [31:0] rdata, input logic ev,
                               input logic [31:0] ea);
      vec_t v;
      v.rst = rst; v.clr = clr; v.addr = addr; v.trans = trans; v.rdy = rdy; v.resp = resp;
      v.chk = chk; v.hsel = hsel; v.ready = ready; v.hresp = hresp; v.rdata = rdata;
      v.ev = ev; v.ea = ea;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      HRESET      = v.rst;
      ERR_CLR     = v.clr;
      HADDR       = v.addr;
      HTRANS      = v.trans;
      HREADYOUT_S = v.rdy;
      HRESP_S     = v.resp;
      exp_q.push_back(v);
   endtask

   task automatic check(input int idx);
      vec_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard row %0d got empty queue want entry", idx);
      end else begin
         e = exp_q.pop_front();
         if (e.chk) begin
            cmp("hsel",      idx, {28'd0, HSEL_S}, {28'd0, e.hsel});
            cmp("hready",    idx, {31'd0, HREADY}, {31'd0, e.ready});
            cmp("hresp",     idx, {31'd0, HRESP},  {31'd0, e.hresp});
            cmp("hrdata",    idx, HRDATA, e.rdata);
            cmp("err_valid", idx, {31'd0, ERR_VALID}, {31'd0, LOG ? e.ev : 1'b0});
            cmp("err_addr",  idx, ERR_ADDR, LOG ? e.ea : 32'd0);
         end
      end
   endtask

   task automatic run_row(input vec_t v, input int idx);
      @(posedge HCLK);
      #1;
      drive(v);
      #6;
      check(idx);
   endtask

   vec_t tbl[27];

   initial begin
      HRDATA_S    = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001, 32'h1234_5678};
      HRESET      = 1'b1;
      ERR_CLR     = 1'b0;
      HADDR       = '0;
      HTRANS      = ID;
      HREADYOUT_S = 4'hF;
      HRESP_S     = 4'h0;

      // reset, then NONSEQ to unmapped space: 2-cycle ERROR
      tbl[0]  = mk(1,0,32'h0000_0000,ID,4'hF,4'h0, 0, 4'b0001,1,0,32'h0,          0,32'h0);
      tbl[1]  = mk(1,0,32'h0000_0000,ID,4'hF,4'h0, 1, 4'b0001,1,0,32'h0,          0,32'h0);
      tbl[2]  = mk(0,0,32'h6000_0000,NS,4'hF,4'h0, 1, 4'b0000,1,0,32'h0,          0,32'h0);
      tbl[3]  = mk(0,0,32'h0000_0000,ID,4'hF,4'h0, 1, 4'b0001,0,1,32'h0,          1,32'h6000_0000);
      tbl[4]  = mk(0,0,32'h0000_0000,ID,4'hF,4'h0, 1, 4'b0001,1,1,32'h0,          1,32'h6000_0000);
      // clear log; write to slave 1; read slave 0 with 3 wait states while HADDR moves on
      tbl[5]  = mk(0,1,32'h5000_0000,NS,4'hF,4'h0, 1, 4'b0010,1,0,32'h1234_5678,  1,32'h6000_0000);
      tbl[6]  = mk(0,0,32'h0000_0000,NS,4'hF,4'h0, 1, 4'b0001,1,0,32'hAAAA_0001,  0,32'h0);
      tbl[7]  = mk(0,0,32'h5100_0000,NS,4'hE,4'h0, 1, 4'b0100,0,0,32'h1234_5678,  0,32'h0);
      tbl[8]  = mk(0,0,32'h5100_0000,NS,4'hE,4'h0, 1, 4'b0100,0,0,32'h1234_5678,  0,32'h0);
      tbl[9]  = mk(0,0,32'h5100_0000,NS,4'hE,4'h0, 1, 4'b0100,0,0,32'h1234_5678,  0,32'h0);
      tbl[10] = mk(0,0,32'h5100_0000,NS,4'hF,4'h0, 1, 4'b0100,1,0,32'h1234_5678,  0,32'h0);
      tbl[11] = mk(0,0,32'h5200_0000,NS,4'hF,4'h0, 1, 4'b1000,1,0,32'hBBBB_0002,  0,32'h0);
      // IDLE / BUSY to unmapped space: OKAY, no log
      tbl[12] = mk(0,0,32'h6000_0000,ID,4'hF,4'h0, 1, 4'b0000,1,0,32'hCCCC_0003,  0,32'h0);
      tbl[13] = mk(0,0,32'h6000_0000,BZ,4'hF,4'h0, 1, 4'b0000,1,0,32'h0,          0,32'h0);
      // two unmapped errors back to back, then mapped with no bubble
      tbl[14] = mk(0,0,32'h7000_0010,NS,4'hF,4'h0, 1, 4'b0000,1,0,32'h0,          0,32'h0);
      tbl[15] = mk(0,0,32'h8000_0020,NS,4'hF,4'h0, 1, 4'b0000,0,1,32'h0,          1,32'h7000_0010);
      tbl[16] = mk(0,0,32'h8000_0020,NS,4'hF,4'h0, 1, 4'b0000,1,1,32'h0,          1,32'h7000_0010);
      tbl[17] = mk(0,0,32'h5000_0000,NS,4'hF,4'h0, 1, 4'b0010,0,1,32'h0,          1,32'h7000_0010);
      tbl[18] = mk(0,0,32'h5000_0000,NS,4'hF,4'h0, 1, 4'b0010,1,1,32'h0,          1,32'h7000_0010);
      // slave 1 returns its own ERROR through the mux
      tbl[19] = mk(0,0,32'h0000_0000,NS,4'hD,4'h2, 1, 4'b0001,0,1,32'hAAAA_0001,  1,32'h7000_0010);
      tbl[20] = mk(0,0,32'h0000_0000,NS,4'hF,4'h2, 1, 4'b0001,1,1,32'hAAAA_0001,  1,32'h7000_0010);
      // clear coinciding with a new error: the new address is captured
      tbl[21] = mk(0,1,32'h6000_0000,NS,4'hF,4'h0, 1, 4'b0000,1,0,32'h1234_5678,  1,32'h7000_0010);
      // reset held two cycles starting in ERR1
      tbl[22] = mk(1,0,32'h0000_0000,ID,4'hF,4'h0, 1, 4'b0001,0,1,32'h0,          1,32'h6000_0000);
      tbl[23] = mk(1,0,32'hFF00_0000,ID,4'hF,4'h0, 1, 4'b0000,1,0,32'h0,          0,32'h0);
      tbl[24] = mk(0,0,32'hFF00_0000,ID,4'hF,4'h0, 1, 4'b0000,1,0,32'h0,          0,32'h0);
      tbl[25] = mk(0,0,32'h5000_0000,NS,4'hF,4'h0, 1, 4'b0010,1,0,32'h0,          0,32'h0);
      tbl[26] = mk(0,0,32'h0000_0000,ID,4'hF,4'h0, 1, 4'b0001,1,0,32'hAAAA_0001,  0,32'h0);

      for (int i = 0; i < 27; i++) run_row(tbl[i], i);

      // reset arriving during a slave wait state abandons the transfer
      run_row(mk(0,0,32'h0000_0000,NS,4'hF,4'h0, 1, 4'b0001,1,0,32'h1234_5678, 0,32'h0), 100);
      run_row(mk(1,0,32'h5000_0000,NS,4'hE,4'h0, 1, 4'b0010,0,0,32'h1234_5678, 0,32'h0), 101);
      run_row(mk(0,0,32'h5000_0000,NS,4'hE,4'h0, 1, 4'b0010,1,0,32'h0,         0,32'h0), 102);
      run_row(mk(0,0,32'h0000_0000,ID,4'hF,4'h0, 1, 4'b0001,1,0,32'hAAAA_0001, 0,32'h0), 103);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
